instruction_memory_loader: RTL

- Parametrised instruction memory with a built-in streaming boot loader.
- After reset it accepts a program image as a byte stream over a valid/ready handshake, packs the bytes into words and writes them sequentially from word 0.
- It then serves registered instruction fetches with alignment and range checking.
- Sits in the instruction-fetch stage, between the external loader source and the PC/decoder path.

---
 rtl/instruction_memory_loader_if.sv | 33 +++
 rtl/instruction_memory_loader.sv | 98 +++++++++
 2 files changed

// File: rtl/instruction_memory_loader_if.sv
// Bus between the boot-image source / fetch stage and the instruction memory loader.
// Groups the byte-stream load handshake and the instruction fetch port.
interface instruction_memory_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32
);
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

    logic                   loadValid;
    logic [7:0]             loadByte;
    logic                   loadLast;
    logic                   loadReady;
    logic                   loadDone;
    logic                   loadError;
    logic [COUNT_WIDTH-1:0] wordCount;
    logic [ADDR_WIDTH-1:0]  fetchAddress;
    logic [DATA_WIDTH-1:0]  fetchInstruction;
    logic                   fetchValid;
    logic                   fetchFault;

    modport master (
        output loadValid, loadByte, loadLast, fetchAddress,
        input  loadReady, loadDone, loadError, wordCount,
               fetchInstruction, fetchValid, fetchFault
    );

    modport slave (
        input  loadValid, loadByte, loadLast, fetchAddress,
        output loadReady, loadDone, loadError, wordCount,
               fetchInstruction, fetchValid, fetchFault
    );
endinterface

// File: rtl/instruction_memory_loader.sv
// Instruction memory with a streaming boot loader: packs an MSB-first byte stream
// into words from index 0, then serves registered, alignment/range-checked fetches.
module instruction_memory_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    instruction_memory_loader_if.slave  bus
);
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int OFFSET_BITS    = $clog2(BYTES_PER_WORD);
    localparam int COUNT_WIDTH    = $clog2(DEPTH + 1);
    localparam int INDEX_WIDTH    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {LOAD, RUN, ERROR} state_t;

    state_t                   state, next_state;
    logic [COUNT_WIDTH-1:0]   word_count;
    logic [OFFSET_BITS-1:0]   byte_count;
    logic [DATA_WIDTH-1:0]    assembly;
    logic [DATA_WIDTH-1:0]    assembled;
    logic                     accept, full, word_complete, write_en;
    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic [ADDR_WIDTH-OFFSET_BITS-1:0] fetch_index;
    logic                              misaligned, in_range;

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        next_state    = state;
        bus.loadReady = (state == LOAD) && !reset;
        bus.loadDone  = (state == RUN) && !reset;
        bus.loadError = (state == ERROR) && !reset;
        accept        = bus.loadValid && bus.loadReady;
        full          = (word_count == COUNT_WIDTH'(DEPTH));
        word_complete = (byte_count == OFFSET_BITS'(BYTES_PER_WORD - 1));
        write_en      = accept && !full && word_complete;
        assembled     = {assembly[DATA_WIDTH-9:0], bus.loadByte};

        if (accept) begin
            if (full)
                next_state = ERROR;
            else if (bus.loadLast)
                next_state = word_complete ? RUN : ERROR;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_count <= '0;
            byte_count <= '0;
            assembly   <= '0;
        end else if (accept && !full) begin
            assembly <= assembled;
            if (word_complete) begin
                byte_count <= '0;
                word_count <= word_count + COUNT_WIDTH'(1);
            end else begin
                byte_count <= byte_count + OFFSET_BITS'(1);
            end
        end
    end

    // NOTE: the array is deliberately not reset; word_count gates every read, so stale words never escape.
    always_ff @(posedge clk) begin
        if (write_en) mem[word_count[INDEX_WIDTH-1:0]] <= assembled;
    end

    assign fetch_index = bus.fetchAddress[ADDR_WIDTH-1:OFFSET_BITS];
    assign misaligned  = (bus.fetchAddress[OFFSET_BITS-1:0] != '0);
    assign in_range    = (ADDR_WIDTH'(fetch_index) < ADDR_WIDTH'(word_count));

    always_ff @(posedge clk) begin
        if (reset || state != RUN) begin
            bus.fetchInstruction <= '0;
            bus.fetchValid       <= 1'b0;
            bus.fetchFault       <= 1'b0;
        end else if (misaligned || !in_range) begin
            bus.fetchInstruction <= '0;
            bus.fetchValid       <= 1'b0;
            bus.fetchFault       <= 1'b1;
        end else begin
            bus.fetchInstruction <= mem[fetch_index[INDEX_WIDTH-1:0]];
            bus.fetchValid       <= 1'b1;
            bus.fetchFault       <= 1'b0;
        end
    end

    assign bus.wordCount = word_count;
endmodule
